// File: rtl/hamming_decode_s_pkg.sv
// rtl/hamming_decode_s_pkg.sv - shared Hamming(7,4) widths and positional indices
package hamming_decode_s_pkg;

  localparam int CW_BITS   = 7;
  localparam int DATA_BITS = 4;
  localparam int SYN_BITS  = 3;

  // Codeword positions, 1-based, in transmission order p1,p2,d1,p4,d2,d3,d4
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int D1 = 3;
  localparam int P4 = 4;
  localparam int D2 = 5;
  localparam int D3 = 6;
  localparam int D4 = 7;

endpackage

// File: rtl/hamming_decode_s_syn.sv
// rtl/hamming_decode_s_syn.sv - combinational Hamming(7,4) syndrome and single-bit correction
module hamming74_syn
  import hamming_decode_s_pkg::*;
#(
  parameter int ERR_CORRECT = 1
) (
  input  logic [CW_BITS:1]     cw_i,
  output logic [SYN_BITS-1:0]  syn_o,
  output logic [DATA_BITS-1:0] data_o
);

  logic [CW_BITS:1] fixed;

  // Syndrome {s4,s2,s1} names the failing position; optionally flip that bit before extracting data
  always_comb begin
    syn_o[0] = cw_i[1] ^ cw_i[3] ^ cw_i[5] ^ cw_i[7];
    syn_o[1] = cw_i[2] ^ cw_i[3] ^ cw_i[6] ^ cw_i[7];
    syn_o[2] = cw_i[4] ^ cw_i[5] ^ cw_i[6] ^ cw_i[7];
    fixed    = cw_i;
    for (int i = 1; i <= CW_BITS; i++) begin
      if ((ERR_CORRECT != 0) && (syn_o == i[SYN_BITS-1:0])) begin
        fixed[i] = ~cw_i[i];
      end
    end
    data_o = {fixed[D1], fixed[D2], fixed[D3], fixed[D4]};
  end

endmodule

// File: rtl/hamming_decode_s.sv
// rtl/hamming_decode_s.sv - serial Hamming(7,4) decoder/corrector with saturating error count
module hamming_decode_s
  import hamming_decode_s_pkg::*;
#(
  parameter int ERR_CORRECT = 1,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 d_in,
  input  logic                 strobe_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic [SYN_BITS-1:0]  syndrome,
  output logic                 err_flag,
  output logic                 valid_out,
  output logic [CNT_W-1:0]     err_count
);

  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [CW_BITS-2:0]   sh_q, sh_d;        // positions 1..6; position 7 comes straight from d_in
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [SYN_BITS-1:0]  syn_q, syn_d;
  logic                 err_q, err_d;
  logic                 valid_q, valid_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [CW_BITS:1]     full_cw;
  logic [SYN_BITS-1:0]  syn_w;
  logic [DATA_BITS-1:0] dec_w;

  // The 7th bit is decoded on the edge it arrives, so it bypasses the capture register
  assign full_cw = {d_in, sh_q};

  hamming74_syn #(.ERR_CORRECT(ERR_CORRECT)) u_syn (
    .cw_i   (full_cw),
    .syn_o  (syn_w),
    .data_o (dec_w)
  );

  // Next-state: capture accepted bits, and on frame end load outputs and bump the error count
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    data_d    = data_q;
    syn_d     = syn_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    cnt_d     = cnt_q;
    if (strobe_in) begin
      if (bit_cnt_q == 3'd6) begin
        bit_cnt_d = 3'd0;
        data_d    = dec_w;
        syn_d     = syn_w;
        err_d     = (syn_w != '0);
        valid_d   = 1'b1;
        if ((syn_w != '0) && (cnt_q != '1)) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        for (int i = 0; i < CW_BITS - 1; i++) begin
          if (bit_cnt_q == i[2:0]) sh_d[i] = d_in;
        end
      end
    end
  end

  // State registers; reset discards any partial frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      syn_q     <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      syn_q     <= syn_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign data_out  = data_q;
  assign syndrome  = syn_q;
  assign err_flag  = err_q;
  assign valid_out = valid_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_hamming_decode_s.sv
// tb/tb_hamming_decode_s.sv - scoreboard bench for hamming_decode_s (correcting and detect-only)
module tb_hamming_decode_s;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d_in = 1'b0;
  logic       strobe_in = 1'b0;
  logic [3:0] data_c, data_n;
  logic [2:0] syn_c, syn_n;
  logic       err_c, err_n;
  logic       valid_c, valid_n;
  logic [7:0] cnt_c;
  logic [2:0] cnt_n;

  always #5 clk = ~clk;

  hamming_decode_s #(.ERR_CORRECT(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .strobe_in(strobe_in),
    .data_out(data_c), .syndrome(syn_c), .err_flag(err_c),
    .valid_out(valid_c), .err_count(cnt_c)
  );

  hamming_decode_s #(.ERR_CORRECT(0), .CNT_W(3)) dut_nc (
    .clk(clk), .rst(rst), .d_in(d_in), .strobe_in(strobe_in),
    .data_out(data_n), .syndrome(syn_n), .err_flag(err_n),
    .valid_out(valid_n), .err_count(cnt_n)
  );

  typedef struct {
    logic [3:0] dc;
    logic [3:0] dn;
    logic [2:0] syn;
    logic       err;
    logic [7:0] cnt;
    logic [2:0] cnt_n;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  int     m_cnt    = 0;
  int     m_cnt_n  = 0;
  int     n_valid  = 0;
  time    last_v_t = 0;
  time    prev_v_t = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:1] encode(input logic [3:0] d);
    logic [7:1] c;
    c[3] = d[3]; c[5] = d[2]; c[6] = d[1]; c[7] = d[0];
    c[1] = c[3] ^ c[5] ^ c[7];
    c[2] = c[3] ^ c[6] ^ c[7];
    c[4] = c[5] ^ c[6] ^ c[7];
    return c;
  endfunction

  // Reference model: syndrome is the XOR of the indices of all set bits
  task automatic push_expect(input logic [7:1] cw);
    exp_t e;
    logic [2:0] s;
    logic [7:1] f;
    s = 3'd0;
    for (int i = 1; i <= 7; i++) if (cw[i]) s = s ^ i[2:0];
    f = cw;
    if (s != 3'd0) f[s] = ~f[s];
    if (s != 3'd0) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt_n < 7) m_cnt_n++;
    end
    e.dc    = {f[3], f[5], f[6], f[7]};
    e.dn    = {cw[3], cw[5], cw[6], cw[7]};
    e.syn   = s;
    e.err   = (s != 3'd0);
    e.cnt   = m_cnt[7:0];
    e.cnt_n = m_cnt_n[2:0];
    sb.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"},  {28'd0, data_c}, 32'd0);
    check({tag, "_syn"},   {29'd0, syn_c},  32'd0);
    check({tag, "_err"},   {31'd0, err_c},  32'd0);
    check({tag, "_valid"}, {31'd0, valid_c}, 32'd0);
    check({tag, "_cnt"},   {24'd0, cnt_c},  32'd0);
    check({tag, "_cnt_n"}, {29'd0, cnt_n},  32'd0);
  endtask

  // Sends the first nbits of cw (position 1 first); expectation is queued just before the 7th bit
  task automatic send_bits(input logic [7:1] cw, input int nbits, input int gap_max, input bit chk_zero);
    for (int i = 1; i <= nbits; i++) begin
      if (i == 7) push_expect(cw);
      d_in = cw[i];
      strobe_in = 1'b1;
      @(posedge clk); #1;
      strobe_in = 1'b0;
      d_in = 1'b0;
      if (chk_zero && i < 7) check_zero("rst_hold");
      if (i < nbits) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    check({tag, "_drain"}, sb.size(), 32'd0);
  endtask

  // Output monitor: every valid pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_c !== valid_n) check("valid_pair", {31'd0, valid_n}, {31'd0, valid_c});
      if (valid_c === 1'b1) begin
        n_valid++;
        prev_v_t = last_v_t;
        last_v_t = $time;
        check("valid_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("data_corr", {28'd0, data_c}, {28'd0, e.dc});
          check("data_nocorr", {28'd0, data_n}, {28'd0, e.dn});
          check("syndrome", {29'd0, syn_c}, {29'd0, e.syn});
          check("syndrome_nc", {29'd0, syn_n}, {29'd0, e.syn});
          check("err_flag", {31'd0, err_c}, {31'd0, e.err});
          check("err_flag_nc", {31'd0, err_n}, {31'd0, e.err});
          check("err_count", {24'd0, cnt_c}, {24'd0, e.cnt});
          check("err_count_sat", {29'd0, cnt_n}, {29'd0, e.cnt_n});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:1] cw;
    int         vb;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean frame 1011 = 0,1,1,0,0,1,1
    cw = 7'b1100110;
    check("encode_1011", {25'd0, encode(4'b1011)}, {25'd0, cw});
    send_bits(cw, 7, 0, 1'b0);
    drain("clean");
    check("clean_count", {24'd0, cnt_c}, 32'd0);
    @(posedge clk); #1;
    check("pulse_one_cycle", {31'd0, valid_c}, 32'd0);

    // Position 5 flipped: syndrome 101, corrected data 1011
    cw = 7'b1110110;
    send_bits(cw, 7, 0, 1'b0);
    drain("single_err");

    // Sweep error position 1..7 on data 0110
    for (int p = 1; p <= 7; p++) begin
      cw = encode(4'b0110);
      cw[p] = ~cw[p];
      send_bits(cw, 7, 1, 1'b0);
    end
    drain("sweep");
    check("sweep_count", {24'd0, cnt_c}, 32'd8);
    check("sat_count", {29'd0, cnt_n}, 32'd7);

    // Gapped strobes, clean 1011; an early valid has no queued entry and is flagged
    vb = n_valid;
    send_bits(encode(4'b1011), 7, 3, 1'b0);
    drain("gapped");
    check("gapped_pulses", n_valid - vb, 32'd1);

    // Reset mid-frame, asserted away from a clock edge
    send_bits(encode(4'b0101), 4, 0, 1'b0);
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    m_cnt = 0;
    m_cnt_n = 0;
    send_bits(encode(4'b1011), 7, 2, 1'b1);
    drain("after_rst");

    // Back-to-back frames with no gap, one with a double error (miscorrected)
    vb = n_valid;
    cw = encode(4'b1001);
    send_bits(cw, 7, 0, 1'b0);
    cw = encode(4'b0011);
    cw[2] = ~cw[2];
    cw[6] = ~cw[6];
    send_bits(cw, 7, 0, 1'b0);
    drain("b2b");
    check("b2b_pulses", n_valid - vb, 32'd2);
    check("b2b_spacing", 32'(last_v_t - prev_v_t), 32'd70);

    // Random frames, single or no error, random gaps
    for (int k = 0; k < 12; k++) begin
      cw = encode(4'($urandom_range(0, 15)));
      vb = $urandom_range(0, 7);
      if (vb != 0) cw[vb] = ~cw[vb];
      send_bits(cw, 7, 2, 1'b0);
    end
    drain("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
